// File: rtl/spram_pkg.sv
// spram_pkg: shared SPRAM geometry, controller state encoding and byte-to-nibble mask expansion.
package spram_pkg;
   localparam int SPRAM_WORDS = 16384;
   localparam int SPRAM_AW    = 14;
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_WAKE   = 3'd1,
      ST_ACCESS = 3'd2,
      ST_ACK    = 3'd3,
      ST_CLEAR  = 3'd4
   } state_t;
   function automatic logic [3:0] be_to_mask(input logic [1:0] be);
      return {be[1], be[1], be[0], be[0]};
   endfunction
endpackage

// File: rtl/spram_bank.sv
// spram_bank: one 16K x 16 SPRAM macro (SB_SPRAM256KA behaviour) with chip select, standby and nibble write mask.
// Ports: clk; cs chip select; we 1=write; mask nibble write enables; addr word address;
//        wdata write data; standby macro standby (no access while high); rdata registered read data.
// SLEEP is tied low and POWEROFF high, so only STANDBY ever gates the macro.
module spram_bank
   import spram_pkg::*;
(
   input  logic                clk,
   input  logic                cs,
   input  logic                we,
   input  logic [3:0]          mask,
   input  logic [SPRAM_AW-1:0] addr,
   input  logic [15:0]         wdata,
   input  logic                standby,
   output logic [15:0]         rdata
);
   localparam logic SLEEP    = 1'b0;
   localparam logic POWEROFF = 1'b1;
   logic [15:0] mem [SPRAM_WORDS];
   logic        live;
   assign live = POWEROFF && !SLEEP && !standby;
   always_ff @(posedge clk) begin
      if (cs && live) begin
         if (we) begin
            for (int i = 0; i < 4; i++)
               if (mask[i]) mem[addr][4*i +: 4] <= wdata[4*i +: 4];
         end else begin
            rdata <= mem[addr];
         end
      end
   end
endmodule

// File: rtl/spram_bank_ctrl.sv
// spram_bank_ctrl: req/ack controller stitching NUM_BANKS SPRAM macros into one address space with idle standby.
// Ports: clk_cpu; rst sync active-high; req/we/be/addr/wdata request fields held until ack;
//        rdata read data valid in the ack cycle; ack one-cycle completion; err out-of-range bank;
//        busy controller not in IDLE; standby per-bank standby status.
// Optional: define SPRAM_CLEAR_EN to zero all banks after every reset (busy stays high meanwhile).
module spram_bank_ctrl
   import spram_pkg::*;
#(
   parameter int NUM_BANKS   = 4,
   parameter int ADDR_W      = SPRAM_AW + $clog2(NUM_BANKS),
   parameter int IDLE_CYCLES = 1024,
   parameter int WAKE_CYCLES = 2
) (
   input  logic                 clk_cpu,
   input  logic                 rst,
   input  logic                 req,
   input  logic                 we,
   input  logic [1:0]           be,
   input  logic [ADDR_W-1:0]    addr,
   input  logic [15:0]          wdata,
   output logic [15:0]          rdata,
   output logic                 ack,
   output logic                 err,
   output logic                 busy,
   output logic [NUM_BANKS-1:0] standby
);
   localparam int BKW = ADDR_W - SPRAM_AW + 1;
   localparam int CW  = $clog2(IDLE_CYCLES + 2);
   localparam int WW  = $clog2(WAKE_CYCLES + 1);
   state_t                state;
   logic                  we_q;
   logic [1:0]            be_q;
   logic [SPRAM_AW-1:0]   off_q, clr_addr, ram_addr;
   logic [15:0]           wdata_q, ram_wdata, rd_mux;
   logic [NUM_BANKS-1:0]  sel_in, sel_q;
   logic [BKW-1:0]        bank_in;
   logic                  oob, wake_needed, clearing, ram_we;
   logic [3:0]            ram_mask;
   logic [WW-1:0]         wcnt;
   logic [15:0]           dout [NUM_BANKS];
   // The extra leading zero keeps the bank field at least one bit wide when NUM_BANKS=1.
   assign bank_in     = BKW'({1'b0, addr} >> SPRAM_AW);
   assign oob         = bank_in >= BKW'(NUM_BANKS);
   assign sel_in      = oob ? '0 : NUM_BANKS'(1) << bank_in;
   assign wake_needed = |(standby & sel_in);
   assign busy        = state != ST_IDLE;
`ifdef SPRAM_CLEAR_EN
   assign clearing = state == ST_CLEAR;
`else
   assign clearing = 1'b0;
   assign clr_addr = '0;
`endif
   assign ram_we    = clearing || we_q;
   assign ram_mask  = clearing ? 4'hF : be_to_mask(be_q);
   assign ram_addr  = clearing ? clr_addr : off_q;
   assign ram_wdata = clearing ? 16'h0000 : wdata_q;
   always_ff @(posedge clk_cpu) begin
      if (rst) begin
`ifdef SPRAM_CLEAR_EN
         state    <= ST_CLEAR;
         clr_addr <= '0;
`else
         state    <= ST_IDLE;
`endif
         ack  <= 1'b0;
         err  <= 1'b0;
         wcnt <= '0;
      end else begin
         ack <= 1'b0;
         err <= 1'b0;
         case (state)
            ST_IDLE: if (req) begin
               we_q    <= we;
               be_q    <= be;
               off_q   <= addr[SPRAM_AW-1:0];
               wdata_q <= wdata;
               sel_q   <= sel_in;
               wcnt    <= '0;
               state   <= oob ? ST_ACK : wake_needed ? ST_WAKE : ST_ACCESS;
               ack     <= oob;
               err     <= oob;
            end
            ST_WAKE: begin
               wcnt  <= wcnt + WW'(1);
               state <= (wcnt == WW'(WAKE_CYCLES - 1)) ? ST_ACCESS : ST_WAKE;
            end
            ST_ACCESS: begin
               state <= ST_ACK;
               ack   <= 1'b1;
            end
            ST_ACK: state <= ST_IDLE;
`ifdef SPRAM_CLEAR_EN
            ST_CLEAR: begin
               clr_addr <= clr_addr + SPRAM_AW'(1);
               state    <= (&clr_addr) ? ST_IDLE : ST_CLEAR;
            end
`endif
            default: state <= ST_IDLE;
         endcase
      end
   end
   for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
      logic [CW-1:0] idle_cnt;
      logic          touch;
      // A bank counts as accessed from the cycle its request is accepted until its ack cycle ends,
      // which also keeps the targeted bank awake through WAKE, ACCESS and ACK.
      assign touch = clearing || (state == ST_IDLE ? req && sel_in[b] : sel_q[b]);
      always_ff @(posedge clk_cpu)
         idle_cnt <= (rst || touch) ? '0 : idle_cnt + CW'(idle_cnt != CW'(IDLE_CYCLES));
      assign standby[b] = (IDLE_CYCLES != 0) && idle_cnt == CW'(IDLE_CYCLES);
      spram_bank u_bank (
         .clk     (clk_cpu),
         .cs      (clearing || (state == ST_ACCESS && sel_q[b])),
         .we      (ram_we),
         .mask    (ram_mask),
         .addr    (ram_addr),
         .wdata   (ram_wdata),
         .standby (standby[b]),
         .rdata   (dout[b])
      );
   end
   always_comb begin
      rd_mux = '0;
      for (int i = 0; i < NUM_BANKS; i++) rd_mux |= sel_q[i] ? dout[i] : 16'h0000;
   end
   assign rdata = (ack && !we_q && !err) ? rd_mux : 16'h0000;
endmodule

// File: tb/tb_spram_bank_ctrl.sv
// tb_spram_bank_ctrl: randomized self-checking bench for spram_bank_ctrl against a word-array and idle-time model.
module tb_spram_bank_ctrl;
   localparam int NB = 3, AW = 16, IDLE = 8, WAKE = 2, WORDS = 16384;
`ifdef SPRAM_CLEAR_EN
   localparam bit CLR = 1'b1;
`else
   localparam bit CLR = 1'b0;
`endif
   logic          clk_cpu = 1'b0;
   logic          rst = 1'b1, req = 1'b0, we = 1'b0;
   logic [1:0]    be = 2'b00;
   logic [AW-1:0] addr = '0;
   logic [15:0]   wdata = '0, rdata;
   logic          ack, err, busy;
   logic [NB-1:0] standby;
   int            total = 0, bad = 0, cyc = 0;
   int            last [NB];
   logic [15:0]   mem [NB*WORDS];
   bit            known [NB*WORDS];
   int            pool [8];

   spram_bank_ctrl #(.NUM_BANKS(NB), .ADDR_W(AW), .IDLE_CYCLES(IDLE), .WAKE_CYCLES(WAKE)) dut (
      .clk_cpu(clk_cpu), .rst(rst), .req(req), .we(we), .be(be), .addr(addr), .wdata(wdata),
      .rdata(rdata), .ack(ack), .err(err), .busy(busy), .standby(standby)
   );

   always #5 clk_cpu = ~clk_cpu;
   always @(posedge clk_cpu) cyc <= cyc + 1;

   initial begin
      #3ms;
      $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   // A bank is in standby once IDLE edges have passed since it was last touched.
   function automatic logic [NB-1:0] pred_sb();
      logic [NB-1:0] p;
      for (int b = 0; b < NB; b++) p[b] = (cyc - last[b]) >= IDLE;
      return p;
   endfunction

   task automatic wait_ready();
      int n = 0;
      while (busy === 1'b1 && n < 20000) begin
         @(posedge clk_cpu); #1;
         n++;
      end
      total++;
      if (n != (CLR ? WORDS : 0)) begin
         bad++;
         $display("FAIL ready: busy cleared after %0d cycles, want %0d", n, CLR ? WORDS : 0);
      end
      if (CLR) for (int i = 0; i < NB*WORDS; i++) begin mem[i] = 16'h0000; known[i] = 1'b1; end
      for (int b = 0; b < NB; b++) last[b] = cyc;
   endtask

   task automatic xact(input bit w, input logic [1:0] b_e, input int bank, input int off,
                       input logic [15:0] d, input string tag);
      int n, lat, idx;
      bit oob, chk;
      logic [NB-1:0] sb;
      logic [15:0] exp_rd;
      oob = bank >= NB;
      idx = bank * WORDS + off;
      sb  = pred_sb();
      total++;
      if (standby !== sb) begin bad++; $display("FAIL %s standby: got %b want %b", tag, standby, sb); end
      lat    = oob ? 1 : (sb[bank] ? 2 + WAKE : 2);
      chk    = oob || w || known[idx];
      exp_rd = (oob || w) ? 16'h0000 : mem[idx];
      req = 1'b1; we = w; be = b_e; addr = AW'(bank * WORDS + off); wdata = d;
      n = 0;
      do begin
         @(posedge clk_cpu); #1;
         n++;
         if (n == 1 && !oob) begin
            total++;
            if (standby[bank] !== 1'b0) begin bad++; $display("FAIL %s wake: standby[%0d]=%b want 0", tag, bank, standby[bank]); end
         end
      end while (ack !== 1'b1 && n < 40);
      total++;
      if (ack !== 1'b1 || n != lat) begin bad++; $display("FAIL %s latency: ack=%b after %0d cycles, want %0d", tag, ack, n, lat); end
      total++;
      if (err !== oob) begin bad++; $display("FAIL %s err: got %b want %b", tag, err, oob); end
      total++;
      if (busy !== 1'b1) begin bad++; $display("FAIL %s busy in ack: got %b want 1", tag, busy); end
      if (chk) begin
         total++;
         if (rdata !== exp_rd) begin bad++; $display("FAIL %s rdata: got %h want %h", tag, rdata, exp_rd); end
      end
      if (!oob && w) begin
         if (known[idx]) mem[idx] = {b_e[1] ? d[15:8] : mem[idx][15:8], b_e[0] ? d[7:0] : mem[idx][7:0]};
         else if (b_e == 2'b11) begin mem[idx] = d; known[idx] = 1'b1; end
      end
      req = 1'b0;
      @(posedge clk_cpu); #1;
      if (!oob) last[bank] = cyc;
      total++;
      if (ack !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL %s after ack: ack=%b busy=%b want 0 0", tag, ack, busy); end
   endtask

   task automatic test_reset();
      rst = 1'b1; req = 1'b0;
      repeat (3) @(posedge clk_cpu);
      #1;
      total++;
      if (ack !== 1'b0 || err !== 1'b0 || rdata !== 16'h0000 || busy !== CLR || standby !== '0) begin
         bad++;
         $display("FAIL reset: ack=%b err=%b rdata=%h busy=%b standby=%b want 0 0 0000 %b 000", ack, err, rdata, busy, standby, CLR);
      end
      rst = 1'b0;
      wait_ready();
   endtask

   task automatic test_basic();
      xact(1'b1, 2'b11, 0, 5, 16'hBEEF, "basic_wr");
      xact(1'b0, 2'b11, 0, 5, 16'h0000, "basic_rd");
   endtask

   task automatic test_byte_enable();
      xact(1'b1, 2'b11, 0, 9, 16'h1234, "be_full");
      xact(1'b1, 2'b10, 0, 9, 16'hAB00, "be_hi");
      xact(1'b0, 2'b00, 0, 9, 16'h0000, "be_rd");
      total++;
      if (mem[9] !== 16'hAB34) begin bad++; $display("FAIL be_model: got %h want ab34", mem[9]); end
      xact(1'b1, 2'b00, 0, 9, 16'h5555, "be_none");
      xact(1'b0, 2'b11, 0, 9, 16'h0000, "be_none_rd");
   endtask

   task automatic test_standby();
      xact(1'b1, 2'b11, 1, 3, 16'h5A5A, "sb_wr");
      repeat (9) @(posedge clk_cpu);
      #1;
      total++;
      if (standby[1] !== 1'b1) begin bad++; $display("FAIL sb_enter: standby[1]=%b want 1", standby[1]); end
      xact(1'b0, 2'b11, 1, 3, 16'h0000, "sb_rd");
   endtask

   task automatic test_error();
      xact(1'b1, 2'b11, 2, 21, 16'hC0DE, "err_pre");
      xact(1'b1, 2'b11, 3, 21, 16'hFFFF, "err_wr");
      xact(1'b0, 2'b11, 3, 21, 16'h0000, "err_rd");
      xact(1'b0, 2'b11, 2, 21, 16'h0000, "err_post");
   endtask

   task automatic test_back_to_back();
      for (int b = 0; b < NB; b++) xact(1'b1, 2'b11, b, 100, 16'(16'h1111 * (b + 1)), "b2b_wr");
      for (int b = 0; b < NB; b++) xact(1'b0, 2'b11, b, 100, 16'h0000, "b2b_rd");
   endtask

   task automatic test_reset_mid();
      xact(1'b0, 2'b11, 1, 3, 16'h0000, "mid_pre");
      req = 1'b1; we = 1'b1; be = 2'b11; addr = AW'(WORDS + 40); wdata = 16'h7777;
      @(posedge clk_cpu); #1;
      rst = 1'b1;
      @(posedge clk_cpu); #1;
      rst = 1'b0; req = 1'b0;
      total++;
      if (ack !== 1'b0 || err !== 1'b0 || busy !== CLR || standby !== '0) begin
         bad++;
         $display("FAIL mid_reset: ack=%b err=%b busy=%b standby=%b want 0 0 %b 000", ack, err, busy, standby, CLR);
      end
      known[WORDS + 40] = 1'b0;
      wait_ready();
      for (int i = 0; i < 3; i++) begin
         @(posedge clk_cpu); #1;
         total++;
         if (ack !== 1'b0) begin bad++; $display("FAIL mid_noack: ack=%b want 0", ack); end
      end
      xact(1'b0, 2'b11, 0, 5, 16'h0000, "mid_rd");
   endtask

   task automatic test_random();
      for (int i = 0; i < 60; i++) begin
         repeat ($urandom_range(0, 12)) @(posedge clk_cpu);
         #1;
         xact(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom_range(0, 3),
              pool[$urandom_range(0, 7)], 16'($urandom), "rand");
      end
   endtask

`ifdef SPRAM_CLEAR_EN
   task automatic test_clear();
      int n = 0;
      bit saw = 1'b0;
      rst = 1'b1;
      @(posedge clk_cpu); #1;
      rst = 1'b0;
      repeat (300) @(posedge clk_cpu);
      #1;
      rst = 1'b1;
      @(posedge clk_cpu); #1;
      rst = 1'b0; req = 1'b1; we = 1'b0; addr = '0;
      while (busy === 1'b1 && n < 20000) begin
         @(posedge clk_cpu); #1;
         n++;
         if (ack === 1'b1) saw = 1'b1;
         if (n == 100) req = 1'b0;
      end
      total++;
      if (n != WORDS) begin bad++; $display("FAIL clear_len: busy for %0d cycles want %0d", n, WORDS); end
      total++;
      if (saw) begin bad++; $display("FAIL clear_ack: ack seen during clear, want none"); end
      for (int i = 0; i < NB*WORDS; i++) begin mem[i] = 16'h0000; known[i] = 1'b1; end
      for (int b = 0; b < NB; b++) last[b] = cyc;
      for (int b = 0; b < NB; b++) begin
         xact(1'b0, 2'b11, b, 0, 16'h0000, "clear_rd0");
         xact(1'b0, 2'b11, b, WORDS - 1, 16'h0000, "clear_rdtop");
      end
   endtask
`endif

   initial begin
      for (int i = 0; i < NB*WORDS; i++) known[i] = 1'b0;
      for (int b = 0; b < NB; b++) last[b] = 0;
      pool = '{0, 5, 9, 21, WORDS - 1, 0, 0, 0};
      for (int i = 5; i < 8; i++) pool[i] = $urandom_range(0, WORDS - 1);
      test_reset();
      test_basic();
      test_byte_enable();
      test_standby();
      test_error();
      test_back_to_back();
      test_reset_mid();
      test_random();
`ifdef SPRAM_CLEAR_EN
      test_clear();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
